// File: rtl/spi_controller.sv
// rtl/spi_controller.sv - SPI mode-0 initiator for 16-bit register frames; optional read path under SPI_CTRL_READ_EN
module spi_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk,
  output logic       copi,
  output logic       ncs,
  input  logic       cipo
);

  localparam int HW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [HW-1:0] HMAX = HW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t        state;
  logic [HW-1:0] hcnt;
  logic [3:0]    bcnt;
  logic [15:0]   shreg;
  logic          frame_rw;

`ifdef SPI_CTRL_READ_EN
  logic [7:0]    rshift;
  assign frame_rw = cmd_rw;
`else
  logic          unused_inputs;
  assign frame_rw      = 1'b1;
  assign unused_inputs = cmd_rw ^ cipo;
`endif

  // Frame sequencer: every output is a register updated here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      sclk      <= 1'b0;
      copi      <= 1'b0;
      ncs       <= 1'b1;
      rdata     <= 8'h00;
      hcnt      <= '0;
      bcnt      <= 4'd0;
      shreg     <= 16'h0000;
`ifdef SPI_CTRL_READ_EN
      rshift    <= 8'h00;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            shreg     <= {frame_rw, cmd_addr, cmd_data};
            copi      <= frame_rw;
            ncs       <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            hcnt      <= '0;
            bcnt      <= 4'd0;
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (hcnt == HMAX) begin
            hcnt  <= '0;
            sclk  <= 1'b1;
            state <= S_SHIFT;
`ifdef SPI_CTRL_READ_EN
            rshift <= {rshift[6:0], cipo};
`endif
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        S_SHIFT: begin
          if (hcnt == HMAX) begin
            hcnt <= '0;
            if (sclk) begin
              // falling edge: advance to the next bit (zeros trail the frame)
              sclk  <= 1'b0;
              copi  <= shreg[14];
              shreg <= {shreg[14:0], 1'b0};
            end else if (bcnt == 4'd15) begin
              copi  <= 1'b0;
              state <= S_HOLD;
            end else begin
              bcnt <= bcnt + 4'd1;
              sclk <= 1'b1;
`ifdef SPI_CTRL_READ_EN
              // the last 8 samples taken remain in rshift at frame end
              rshift <= {rshift[6:0], cipo};
`endif
            end
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (hcnt == HMAX) begin
            hcnt  <= '0;
            ncs   <= 1'b1;
            state <= S_GAP;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        S_GAP: begin
          if (hcnt == HMAX) begin
            hcnt      <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= S_IDLE;
`ifdef SPI_CTRL_READ_EN
            rdata     <= rshift;
`endif
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
